datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the single-port datamem (64 x 32-bit). Requester 0 is the CPU load/store path; requester 1 is the debug/DMA loader. The block accepts one request at a time over a valid/ready handshake, registers it, and drives memread/memwrite/addr/data_in for exactly one cycle. It returns a one-cycle response pulse with read data or a write acknowledge.

Parameters:
ADDR_W, 6, word address width; must match the datamem addr port
DATA_W, 32, data width; must match datamem data_in/data_out

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request present
req0_we  in  1  port 0: 1 = write, 0 = read
req0_addr  in  ADDR_W  port 0 word address
req0_wdata  in  DATA_W  port 0 write data
req0_ready  out  1  port 0 request accepted this cycle
resp0_valid  out  1  port 0 response pulse
resp0_rdata  out  DATA_W  port 0 read data; 0 for writes
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata  same as port 0, for port 1
mem_read  out  1  to datamem memread
mem_write  out  1  to datamem memwrite
mem_addr  out  ADDR_W  to datamem addr
mem_wdata  out  DATA_W  to datamem data_in
mem_rdata  in  DATA_W  from datamem data_out; combinational read
busy  out  1  high whenever state != IDLE

Behaviour:
- Datamem contract: write commits on the clk rising edge while memwrite=1; read data is valid combinationally in the same cycle as addr/memread.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the arbitration winner.
  - On a handshake (valid & ready): latch we/addr/wdata and the granted port into registers, update last_grant, and go to ACCESS.
  - No valid requests: stay in IDLE.
- Arbitration:
  - Only one valid request: that port wins.
  - Both valid: the port != last_grant wins (strict alternation under contention).
- ACCESS (exactly 1 cycle):
  - Drive mem_addr and mem_wdata from the latched request.
  - mem_read = ~we, mem_write = we.
  - Reads: capture mem_rdata into the response register on the exiting edge. Writes: load 0 into the response register.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - respN_valid = 1 for the granted port only.
  - respN_rdata holds the captured value from RESP until the next response to that port.
  - Next state: IDLE.
- Latency and throughput:
  - Handshake edge -> ACCESS next cycle -> resp_valid one cycle later, i.e. 2 cycles after acceptance.
  - Throughput is 1 transaction per 3 cycles. No request is accepted in ACCESS or RESP; both readys are 0 there.
- Output rules:
  - mem_read and mem_write are never both 1.
  - Both are 0 outside ACCESS.
  - mem_addr and mem_wdata hold their last latched values outside ACCESS.
- Requester rule: once valid is asserted, the requester holds valid/we/addr/wdata stable until ready. The arbiter does not support request withdrawal.
- Reset (rst_n=0, async):
  - state = IDLE, last_grant = 1 (port 0 wins the first tie).
  - All outputs 0: mem_read, mem_write, mem_addr, mem_wdata, readys, resp valids, resp rdata, busy.
- Reset mid-operation:
  - mem_write drops immediately, the transaction is abandoned, and no response is issued.
  - After rst_n rises, arbitration restarts from IDLE.
- Same-cycle events: a response in RESP and a new valid arriving in that cycle do not interact; the new request is accepted in the following IDLE cycle.
- Address wrap: none. ADDR_W covers the full memory; addresses pass through unmodified.

Test Plan:
- Single write: port0 writes addr 20, data 9. Expect req0_ready=1 on accept; next cycle mem_write=1, mem_addr=20, mem_wdata=9, mem_read=0; next cycle resp0_valid=1, resp0_rdata=0.
- Read-back: port0 reads addr 20 after the write. Expect mem_read=1 in ACCESS; resp0_valid one cycle later with resp0_rdata=9.
- Contention: both ports valid continuously after reset (port0 write addr 30 = 30, port1 read addr 20). Expect grant order 0,1,0,1; grants 3 cycles apart; port1 gets rdata=9.
- Single requester: only port1 valid, writes addr 5 = 0xDEADBEEF, then reads it back. Expect both accepted without waiting on port0; read returns 0xDEADBEEF.
- Reset mid-ACCESS: assert rst_n=0 during a write ACCESS cycle. Expect mem_write=0 immediately, no resp_valid, busy=0, and port0 winning the first tie after release.
- Protocol checks on every cycle: mem_read & mem_write never both 1; readys are 0 while busy=1; at most one resp_valid high at a time.

Source files
------------

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-port round-robin arbiter/sequencer for the 64x32 datamem
//
// Accepts one request at a time from two requesters over a valid/ready
// handshake, performs exactly one memory access cycle, then issues a
// one-cycle response pulse to the granted requester.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/we/addr/wdata  request from port 0 (CPU) / port 1 (debug/DMA)
//   req{0,1}_ready             combinational accept, arbitration winner only, IDLE only
//   resp{0,1}_valid            one-cycle response pulse
//   resp{0,1}_rdata            read data of the last response to that port (0 for writes)
//   mem_read/mem_write/mem_addr/mem_wdata  to datamem; strobes only in ACCESS
//   mem_rdata                  from datamem, combinational read
//   busy                       high whenever the sequencer is not IDLE
module datamem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              grant0, grant1;
  logic              accept;

  // Under contention the port that did not win last time goes next.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps readys low while reset is held even though
        // the state register already reads IDLE.
        req0_ready = grant0 & rst_n;
        req1_ready = grant1 & rst_n;
        accept     = grant0 | grant1;
        if (accept) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        port_q       <= grant1;
        last_grant_q <= grant1;
        we_q         <= grant1 ? req1_we    : req0_we;
        addr_q       <= grant1 ? req1_addr  : req0_addr;
        wdata_q      <= grant1 ? req1_wdata : req0_wdata;
      end
      if (state_q == ACCESS) begin
        // Writes report 0 so a stale read value never looks like a write result.
        if (port_q) rdata1_q <= we_q ? '0 : mem_rdata;
        else        rdata0_q <= we_q ? '0 : mem_rdata;
      end
    end
  end

  assign mem_read    = (state_q == ACCESS) & ~we_q;
  assign mem_write   = (state_q == ACCESS) &  we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = (state_q != IDLE);
  assign resp0_valid = (state_q == RESP) & ~port_q;
  assign resp1_valid = (state_q == RESP) &  port_q;
  assign resp0_rdata = rdata0_q;
  assign resp1_rdata = rdata1_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - directed self-checking bench for datamem_arbiter
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [5:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ready, resp0_valid;
  logic [31:0] resp0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ready, resp1_valid;
  logic [31:0] resp1_rdata;
  logic        mem_read, mem_write, busy;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64] = '{default: 32'h0};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  datamem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle protocol invariants.
  always @(negedge clk) begin
    #2;
    check("rw_excl", {31'b0, mem_read & mem_write}, 32'd0);
    check("ready_busy", {31'b0, busy & (req0_ready | req1_ready)}, 32'd0);
    check("resp_excl", {31'b0, resp0_valid & resp1_valid}, 32'd0);
  end

  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [5:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  task automatic do_txn(input int port, input logic we, input logic [5:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        output int waited);
    logic rdy;
    @(negedge clk);
    set_req(port, 1'b1, we, addr, wdata);
    waited = 0;
    #1;
    rdy = (port == 0) ? req0_ready : req1_ready;
    while (!rdy && waited < 8) begin
      @(negedge clk); #1;
      waited++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) begin
      check("accept_timeout", 32'd1, 32'd0);
      set_req(port, 1'b0, 1'b0, 6'd0, 32'd0);
      return;
    end
    check("idle_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk); #1;
    check("acc_read", {31'b0, mem_read}, {31'b0, ~we});
    check("acc_write", {31'b0, mem_write}, {31'b0, we});
    check("acc_addr", {26'b0, mem_addr}, {26'b0, addr});
    if (we) check("acc_wdata", mem_wdata, wdata);
    check("acc_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); #1;
    check("resp0_valid", {31'b0, resp0_valid}, (port == 0) ? 32'd1 : 32'd0);
    check("resp1_valid", {31'b0, resp1_valid}, (port == 1) ? 32'd1 : 32'd0);
    check("resp_rdata", (port == 0) ? resp0_rdata : resp1_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int g_port [4];
    int g_cyc  [4];

    // Reset state, with a request present to confirm ready stays low.
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", {31'b0, req0_ready}, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp0", {31'b0, resp0_valid}, 32'd0);
    check("rst_rdata1", resp1_rdata, 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // Single write then read-back on port 0.
    do_txn(0, 1'b1, 6'd20, 32'd9, 32'd0, w);
    check("mem20", mem[20], 32'd9);
    do_txn(0, 1'b0, 6'd20, 32'd0, 32'd9, w);
    @(negedge clk); #1;
    check("post_resp_idle", {31'b0, resp0_valid | busy}, 32'd0);
    check("rdata0_hold", resp0_rdata, 32'd9);

    // Contention right after reset: expect 0,1,0,1 three cycles apart.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 6'd30, 32'd30);
    set_req(1, 1'b1, 1'b0, 6'd20, 32'd0);
    n = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (req0_ready && n < 4) begin g_port[n] = 0; g_cyc[n] = cyc; n++; end
      if (req1_ready && n < 4) begin g_port[n] = 1; g_cyc[n] = cyc; n++; end
    end
    set_req(0, 1'b0, 1'b0, 6'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 6'd0, 32'd0);
    check("cont_ngrants", n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        check("cont_port", g_port[i], i % 2);
        check("cont_cyc", g_cyc[i], 3 * i);
      end
    end
    check("cont_rdata1", resp1_rdata, 32'd9);
    check("cont_rdata0", resp0_rdata, 32'd0);
    check("mem30", mem[30], 32'd30);

    // Port 1 alone, right after port 1 won last: no waiting.
    do_txn(1, 1'b1, 6'd5, 32'hDEADBEEF, 32'd0, w);
    check("p1_wr_wait", w, 32'd0);
    do_txn(1, 1'b0, 6'd5, 32'd0, 32'hDEADBEEF, w);
    check("p1_rd_wait", w, 32'd0);

    // Reset during a write ACCESS cycle.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 6'd40, 32'h55);
    #1;
    check("mr_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk); #1;
    check("mr_write_pre", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_write_drop", {31'b0, mem_write}, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); #1;
    check("mr_no_resp", {30'b0, resp0_valid, resp1_valid}, 32'd0);
    check("mr_mem40", mem[40], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 6'd20, 32'd0);
    set_req(1, 1'b1, 1'b0, 6'd5, 32'd0);
    #1;
    check("mr_tie_ready0", {31'b0, req0_ready}, 32'd1);
    check("mr_tie_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 6'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 6'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("mr_resp0_valid", {31'b0, resp0_valid}, 32'd1);
    check("mr_resp0_rdata", resp0_rdata, 32'd9);
    repeat (2) @(negedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
